// File: rtl/free_list_pkg.sv
// Shared rename-core constants and the physical register tag type.
package free_list_pkg;
    localparam int PREG_W  = 5;
    localparam int AREG_W  = 3;
    localparam int ISSUE_W = 3;
    localparam int P_NUM   = 1 << PREG_W;
    localparam int A_NUM   = 1 << AREG_W;
    localparam int DEPTH   = 32;
    localparam int IDX_W   = $clog2(DEPTH);
    localparam int PTR_W   = IDX_W + 1;

    typedef logic [PREG_W-1:0] preg_t;
endpackage

// File: rtl/free_list.sv
// Physical register free list: speculative head for rename allocation, committed head for
// one-cycle flush recovery, tail fed by tags released at ROB retirement.
module free_list
    import free_list_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       freeze_front,
    input  logic       alloc_x,
    input  logic       alloc_y,
    input  logic       alloc_z,
    output logic [4:0] Pw_new_x,
    output logic [4:0] Pw_new_y,
    output logic [4:0] Pw_new_z,
    output logic       full_PRF,
    input  logic       RegWr_x,
    input  logic       RegWr_y,
    input  logic       RegWr_z,
    input  logic       exp_x,
    input  logic       exp_y,
    input  logic       exp_z,
    input  logic [4:0] Pw_retire_x,
    input  logic [4:0] Pw_retire_y,
    input  logic [4:0] Pw_retire_z
);

    preg_t             mem_q [DEPTH];
    preg_t             mem_d [DEPTH];
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [PTR_W-1:0]  cmt_head_q, cmt_head_d;
    logic [PTR_W-1:0]  free_cnt;
    logic [2:0]        alloc_vec;
    logic [2:0]        rel_vec;
    logic [1:0]        n_rel;
    logic              fire;

    function automatic logic [1:0] count3(input logic [2:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
    endfunction

    function automatic logic [IDX_W-1:0] slot_idx(input logic [PTR_W-1:0] base,
                                                  input logic [1:0] off);
        logic [PTR_W-1:0] sum;
        sum = base + PTR_W'(off);
        return sum[IDX_W-1:0];
    endfunction

    always_comb begin
        free_cnt  = tail_q - head_q;
        full_PRF  = free_cnt < PTR_W'(ISSUE_W);
        alloc_vec = {alloc_z, alloc_y, alloc_x};
        fire      = ~full_PRF & ~freeze_front & ~flush;
        Pw_new_x  = mem_q[slot_idx(head_q, 2'd0)];
        Pw_new_y  = mem_q[slot_idx(head_q, {1'b0, alloc_x})];
        Pw_new_z  = mem_q[slot_idx(head_q, count3({1'b0, alloc_y, alloc_x}))];
    end

    // An excepting slot blocks its own release and every younger slot's release.
    always_comb begin
        rel_vec[0] = RegWr_x & ~exp_x;
        rel_vec[1] = RegWr_y & ~exp_x & ~exp_y;
        rel_vec[2] = RegWr_z & ~exp_x & ~exp_y & ~exp_z;
        n_rel      = count3(rel_vec);
    end

    always_comb begin
        mem_d = mem_q;
        if (rel_vec[0]) mem_d[slot_idx(tail_q, 2'd0)] = Pw_retire_x;
        if (rel_vec[1]) mem_d[slot_idx(tail_q, {1'b0, rel_vec[0]})] = Pw_retire_y;
        if (rel_vec[2]) mem_d[slot_idx(tail_q, count3({1'b0, rel_vec[1:0]}))] = Pw_retire_z;
    end

    // Each release commits the matching allocation, so cmt_head moves in lockstep with tail.
    always_comb begin
        tail_d     = tail_q + PTR_W'(n_rel);
        cmt_head_d = cmt_head_q + PTR_W'(n_rel);
        head_d     = head_q;
        if (flush) begin
            head_d = cmt_head_d;
        end else if (fire) begin
            head_d = head_q + PTR_W'(count3(alloc_vec));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= (k < P_NUM - A_NUM) ? preg_t'(A_NUM + k) : '0;
            end
            head_q     <= '0;
            cmt_head_q <= '0;
            tail_q     <= PTR_W'(P_NUM - A_NUM);
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            cmt_head_q <= cmt_head_d;
            tail_q     <= tail_d;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Randomised scoreboard bench for free_list against a queue-based model of free and in-flight tags.
module tb_free_list;
    import free_list_pkg::*;

    typedef struct {
        logic [2:0] mask;
        preg_t      tx;
        preg_t      ty;
        preg_t      tz;
        logic       full;
        bit         chk_tags;
    } exp_t;

    logic clk, rst, flush, freeze_front;
    logic alloc_x, alloc_y, alloc_z;
    logic [4:0] Pw_new_x, Pw_new_y, Pw_new_z;
    logic full_PRF;
    logic RegWr_x, RegWr_y, RegWr_z;
    logic exp_x, exp_y, exp_z;
    logic [4:0] Pw_retire_x, Pw_retire_y, Pw_retire_z;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    int   free_m[$];
    int   spec_m[$];

    free_list dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze_front(freeze_front),
        .alloc_x(alloc_x), .alloc_y(alloc_y), .alloc_z(alloc_z),
        .Pw_new_x(Pw_new_x), .Pw_new_y(Pw_new_y), .Pw_new_z(Pw_new_z),
        .full_PRF(full_PRF),
        .RegWr_x(RegWr_x), .RegWr_y(RegWr_y), .RegWr_z(RegWr_z),
        .exp_x(exp_x), .exp_y(exp_y), .exp_z(exp_z),
        .Pw_retire_x(Pw_retire_x), .Pw_retire_y(Pw_retire_y), .Pw_retire_z(Pw_retire_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The model holds free tags in hand-out order and allocated-but-uncommitted tags in age order.
    task automatic modelReset();
        free_m.delete();
        spec_m.delete();
        for (int k = A_NUM; k < P_NUM; k++) free_m.push_back(k);
    endtask

    function automatic logic [2:0] relMask(input logic [2:0] rw, input logic [2:0] ex);
        logic [2:0] r;
        bit blocked;
        blocked = 0;
        for (int i = 0; i < 3; i++) begin
            if (ex[i]) blocked = 1;
            r[i] = rw[i] && !blocked;
        end
        return r;
    endfunction

    task automatic checkOutput(input exp_t e);
        preg_t act [3];
        preg_t req [3];
        act[0] = Pw_new_x; act[1] = Pw_new_y; act[2] = Pw_new_z;
        req[0] = e.tx;     req[1] = e.ty;     req[2] = e.tz;
        checks++;
        if (full_PRF !== e.full) begin
            errors++;
            $display("[TB] FAIL full_PRF: actual %0b required %0b at %0t", full_PRF, e.full, $time);
        end
        if (e.chk_tags) begin
            for (int i = 0; i < 3; i++) begin
                if (e.mask[i]) begin
                    checks++;
                    if (act[i] !== req[i]) begin
                        errors++;
                        $display("[TB] FAIL Pw_new slot %0d: actual %0d required %0d at %0t",
                                 i, act[i], req[i], $time);
                    end
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [2:0] al, input logic fl, input logic fz,
                                 input logic [2:0] rw, input logic [2:0] ex,
                                 input preg_t rx, input preg_t ry, input preg_t rz);
        exp_t e;
        logic [2:0] rel;
        preg_t rtag [3];
        int k;
        @(negedge clk);
        {alloc_z, alloc_y, alloc_x} = al;
        flush = fl;
        freeze_front = fz;
        {RegWr_z, RegWr_y, RegWr_x} = rw;
        {exp_z, exp_y, exp_x} = ex;
        Pw_retire_x = rx; Pw_retire_y = ry; Pw_retire_z = rz;

        e.mask = al;
        e.full = free_m.size() < ISSUE_W;
        e.chk_tags = !e.full;
        e.tx = '0; e.ty = '0; e.tz = '0;
        k = 0;
        if (!e.full) begin
            if (al[0]) begin e.tx = preg_t'(free_m[k]); k++; end
            if (al[1]) begin e.ty = preg_t'(free_m[k]); k++; end
            if (al[2]) begin e.tz = preg_t'(free_m[k]); k++; end
        end
        exp_q.push_back(e);

        rel = relMask(rw, ex);
        rtag[0] = rx; rtag[1] = ry; rtag[2] = rz;
        if (!e.full && !fz && !fl) begin
            for (int i = 0; i < $countones(al); i++) spec_m.push_back(free_m.pop_front());
        end
        for (int i = 0; i < $countones(rel); i++) void'(spec_m.pop_front());
        for (int i = 0; i < 3; i++) if (rel[i]) free_m.push_back(int'(rtag[i]));
        if (fl) begin
            while (spec_m.size() > 0) free_m.push_front(spec_m.pop_back());
        end
    endtask

    task automatic idleCycle();
        applyStimulus(3'b000, 1'b0, 1'b0, 3'b000, 3'b000, '0, '0, '0);
    endtask

    task automatic pulseReset();
        @(posedge clk);
        #2 rst = 1'b1;
        modelReset();
        #1 rst = 1'b0;
    endtask

    // Monitor: every cycle the DUT presents tags and full_PRF for the inputs just driven.
    initial begin
        exp_t e;
        logic [PTR_W-1:0] span;
        forever begin
            @(negedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput(e);
            end
            span = dut.tail_q - dut.cmt_head_q;
            checks++;
            if (span !== PTR_W'(P_NUM - A_NUM)) begin
                errors++;
                $display("[TB] FAIL tail-cmt_head: actual %0d required %0d at %0t",
                         span, P_NUM - A_NUM, $time);
            end
        end
    end

    initial begin
        exp_t e0;
        logic [2:0] al, rw, ex;
        logic fl, fz;
        rst = 1'b1;
        {alloc_z, alloc_y, alloc_x} = 3'b000;
        flush = 0; freeze_front = 0;
        {RegWr_z, RegWr_y, RegWr_x} = 3'b000;
        {exp_z, exp_y, exp_x} = 3'b000;
        Pw_retire_x = '0; Pw_retire_y = '0; Pw_retire_z = '0;
        modelReset();
        #1 {alloc_z, alloc_y, alloc_x} = 3'b111;
        #1;
        e0.mask = 3'b111; e0.tx = 5'd8; e0.ty = 5'd9; e0.tz = 5'd10;
        e0.full = 1'b0; e0.chk_tags = 1;
        checkOutput(e0);
        {alloc_z, alloc_y, alloc_x} = 3'b000;
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed: fill, full, retire, flush, exception, freeze");
        for (int c = 0; c < 9; c++) applyStimulus(3'b111, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b111, 0, 0, 3'b111, 3'b000, 5'd0, 5'd1, 5'd2);
        applyStimulus(3'b111, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        idleCycle();

        pulseReset();
        applyStimulus(3'b111, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b011, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b000, 1, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b111, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b000, 1, 0, 3'b111, 3'b010, 5'd3, 5'd4, 5'd5);
        applyStimulus(3'b101, 0, 1, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b111, 1, 0, 3'b000, 3'b000, '0, '0, '0);
        applyStimulus(3'b101, 0, 0, 3'b000, 3'b000, '0, '0, '0);
        idleCycle();

        $display("[TB] random phase");
        for (int c = 0; c < 600; c++) begin
            if (c == 300) pulseReset();
            al = 3'($urandom);
            if ($urandom_range(0, 3) != 0) al = al | 3'($urandom);
            fl = ($urandom_range(0, 11) == 0);
            fz = ($urandom_range(0, 5) == 0);
            rw = 3'($urandom);
            ex = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b000;
            for (int i = 2; i >= 0; i--) begin
                if ($countones(relMask(rw, ex)) > spec_m.size()) rw[i] = 1'b0;
            end
            applyStimulus(al, fl, fz, rw, ex,
                          preg_t'($urandom), preg_t'($urandom), preg_t'($urandom));
        end
        idleCycle();

        @(negedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: actual %0d pending required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
